// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//
// Four requesters (A=0, B=1, C=2, D=3) compete for a single registered output
// slot. A round-robin arbiter picks one requester whenever the output register
// can take a new word. A 4:1 data mux steered by sel_o delivers that word into
// the output register. The output register follows a valid/ready handshake, so
// a FULL register that is being drained can be refilled in the same cycle.
//
// Ports
//   clk_i        single clock, all state updates on the rising edge
//   reset_i      synchronous active-high reset
//   req_i[3:0]   one request bit per requester
//   dataA_i..dataD_i  requester words, held stable while the request is up
//   outReady_i   consumer accepts outData_o when outValid_o is also high
//   gnt_o[3:0]   one-hot grant, high only in the cycle a word is captured
//   sel_o[1:0]   mux select: winner in a capture cycle, otherwise last winner
//   outData_o    registered captured word
//   outValid_o   outData_o holds a word that has not been consumed yet
//   xferCount_o  free-running count of captured words (wraps at 16 bits)
// ---------------------------------------------------------------------------

module Mux4 #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  input  logic [WIDTH-1:0] in3_i,
  output logic [WIDTH-1:0] out_o
);

  // Plain 4:1 data mux; the select covers all four codes.
  always_comb begin
    out_o = in0_i;
    case (sel_i)
      2'd0: out_o = in0_i;
      2'd1: out_o = in1_i;
      2'd2: out_o = in2_i;
      2'd3: out_o = in3_i;
      default: out_o = in0_i;
    endcase
  end

endmodule

module rr_mux_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [3:0]            req_i,
  input  logic [DATA_WIDTH-1:0] dataA_i,
  input  logic [DATA_WIDTH-1:0] dataB_i,
  input  logic [DATA_WIDTH-1:0] dataC_i,
  input  logic [DATA_WIDTH-1:0] dataD_i,
  input  logic                  outReady_i,
  output logic [3:0]            gnt_o,
  output logic [1:0]            sel_o,
  output logic [DATA_WIDTH-1:0] outData_o,
  output logic                  outValid_o,
  output logic [15:0]           xferCount_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] outData_q, outData_d;
  logic [1:0]            lastSel_q, lastSel_d;
  logic [15:0]           xferCount_q, xferCount_d;

  logic [1:0]            winner;
  logic [1:0]            searchIdx;
  logic                  anyReq;
  logic                  captureSlot;
  logic                  capture;
  logic [DATA_WIDTH-1:0] muxOut;

  // Round-robin search starting just after the last winner. Offset 4 wraps
  // back to lastSel_q itself, so the previous winner has lowest priority.
  always_comb begin
    winner    = lastSel_q;
    searchIdx = lastSel_q;
    anyReq    = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      searchIdx = lastSel_q + 2'(k);
      if (!anyReq && req_i[searchIdx]) begin
        winner = searchIdx;
        anyReq = 1'b1;
      end
    end
  end

  // A slot opens when the register is empty or is being drained this cycle;
  // reset closes every slot so nothing is granted while it is held.
  always_comb begin
    captureSlot = !reset_i && ((state_q == EMPTY) || outReady_i);
    capture     = captureSlot && anyReq;
  end

  // Grant and select are combinational so a requester sees its grant in the
  // same cycle its word is taken.
  always_comb begin
    gnt_o = 4'b0000;
    sel_o = lastSel_q;
    if (reset_i) begin
      sel_o = 2'b11;
    end else if (capture) begin
      sel_o = winner;
      gnt_o = 4'b0001 << winner;
    end
  end

  Mux4 #(
    .WIDTH (DATA_WIDTH)
  ) uDataMux (
    .sel_i (sel_o),
    .in0_i (dataA_i),
    .in1_i (dataB_i),
    .in2_i (dataC_i),
    .in3_i (dataD_i),
    .out_o (muxOut)
  );

  // Next-state logic: a capture always refills the register (even when a
  // word is being drained in the same cycle); a drain with no request empties it.
  always_comb begin
    state_d     = state_q;
    outData_d   = outData_q;
    lastSel_d   = lastSel_q;
    xferCount_d = xferCount_q;
    if (capture) begin
      state_d     = FULL;
      outData_d   = muxOut;
      lastSel_d   = winner;
      xferCount_d = xferCount_q + 16'd1;
    end else if ((state_q == FULL) && outReady_i) begin
      state_d = EMPTY;
    end
  end

  // State registers. lastSel resets to 3 so the first search starts at A.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= EMPTY;
      outData_q   <= '0;
      lastSel_q   <= 2'b11;
      xferCount_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      outData_q   <= outData_d;
      lastSel_q   <= lastSel_d;
      xferCount_q <= xferCount_d;
    end
  end

  assign outData_o   = outData_q;
  assign outValid_o  = (state_q == FULL);
  assign xferCount_o = xferCount_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter
//
// Directed and randomized bench for rr_mux_arbiter. A behavioural model keeps
// the output slot contents, the last winner index and the capture count, and
// derives the expected grant/select/outputs every cycle. Inputs change on the
// falling edge and outputs are sampled one time unit later.
// ---------------------------------------------------------------------------

module tb_rr_mux_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic        outReady;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [31:0] outData;
  logic        outValid;
  logic [15:0] xferCount;
  logic [31:0] dataArr [4];

  int testCount = 0;
  int failCount = 0;

  // Behavioural model of the output slot.
  logic        mValid;
  logic [31:0] mData;
  int          mLast;
  logic [15:0] mCount;

  rr_mux_arbiter #(
    .DATA_WIDTH (32)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_i       (req),
    .dataA_i     (dataArr[0]),
    .dataB_i     (dataArr[1]),
    .dataC_i     (dataArr[2]),
    .dataD_i     (dataArr[3]),
    .outReady_i  (outReady),
    .gnt_o       (gnt),
    .sel_o       (sel),
    .outData_o   (outData),
    .outValid_o  (outValid),
    .xferCount_o (xferCount)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner index from the round-robin rule, -1 when nothing can be captured.
  function automatic int modelWinner();
    if (reset || (mValid && !outReady)) return -1;
    for (int k = 1; k <= 4; k++) begin
      if (req[(mLast + k) % 4]) return (mLast + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] modelGnt();
    int w = modelWinner();
    if (w < 0) return 4'b0000;
    return 4'(1 << w);
  endfunction

  function automatic logic [1:0] modelSel();
    int w = modelWinner();
    if (reset) return 2'd3;
    if (w >= 0) return 2'(w);
    return 2'(mLast);
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic rdy, input logic rst);
    req      = r;
    outReady = rdy;
    reset    = rst;
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".gnt"},      {28'd0, gnt},      {28'd0, modelGnt()});
    checkVal({tag, ".sel"},      {30'd0, sel},      {30'd0, modelSel()});
    checkVal({tag, ".outData"},  outData,           mData);
    checkVal({tag, ".outValid"}, {31'd0, outValid}, {31'd0, mValid});
    checkVal({tag, ".xfer"},     {16'd0, xferCount}, {16'd0, mCount});
  endtask

  // Advance one clock edge, update the model from the inputs seen at that
  // edge, then return on the following falling edge.
  task automatic tick();
    int w;
    @(posedge clk);
    w = modelWinner();
    if (reset) begin
      mValid = 1'b0;
      mData  = 32'd0;
      mLast  = 3;
      mCount = 16'd0;
    end else if (w >= 0 && req != 4'b0000) begin
      mValid = 1'b1;
      mData  = dataArr[w];
      mLast  = w;
      mCount = mCount + 16'd1;
    end else if (mValid && outReady) begin
      mValid = 1'b0;
    end
    @(negedge clk);
  endtask

  logic [3:0] rrExp [5];

  initial begin
    mValid = 1'b0;
    mData  = 32'd0;
    mLast  = 3;
    mCount = 16'd0;
    for (int i = 0; i < 4; i++) dataArr[i] = 32'd0;
    reset    = 1'b1;
    req      = 4'b0000;
    outReady = 1'b0;
    rrExp[0] = 4'b0001; rrExp[1] = 4'b0010; rrExp[2] = 4'b0100;
    rrExp[3] = 4'b1000; rrExp[4] = 4'b0001;
    @(negedge clk);

    // Reset with all requests up: no grant, select parked at 3.
    applyStimulus(4'b1111, 1'b1, 1'b1);
    checkVal("rstGnt", {28'd0, gnt}, 32'd0);
    checkVal("rstSel", {30'd0, sel}, 32'd3);
    tick();
    checkOutput("reset");
    checkVal("rstData", outData, 32'd0);
    checkVal("rstValid", {31'd0, outValid}, 32'd0);
    tick();

    // Single request from C.
    dataArr[2] = 32'hCAFE0002;
    applyStimulus(4'b0100, 1'b1, 1'b0);
    checkOutput("reqC");
    checkVal("reqC.gntConst", {28'd0, gnt}, 32'b0100);
    checkVal("reqC.selConst", {30'd0, sel}, 32'd2);
    tick();
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkVal("reqC.data", outData, 32'hCAFE0002);
    checkVal("reqC.valid", {31'd0, outValid}, 32'd1);
    checkVal("reqC.xfer", {16'd0, xferCount}, 32'd1);
    tick();

    // Fresh reset, then all four requesting: grants rotate A,B,C,D,A.
    applyStimulus(4'b0000, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) dataArr[i] = 32'hA0A0_0000 + 32'(i);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0);
      checkOutput("rr");
      checkVal($sformatf("rr.gnt%0d", i), {28'd0, gnt}, {28'd0, rrExp[i]});
      tick();
      checkVal($sformatf("rr.data%0d", i), outData, 32'hA0A0_0000 + 32'(i % 4));
    end

    // Stall: FULL with 11111111, consumer not ready, B requesting.
    dataArr[0] = 32'h11111111;
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("loadA");
    tick();
    dataArr[1] = 32'hBBBB0001;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0010, 1'b0, 1'b0);
      checkOutput("stall");
      checkVal("stall.gnt", {28'd0, gnt}, 32'd0);
      checkVal("stall.data", outData, 32'h11111111);
      tick();
    end
    applyStimulus(4'b0010, 1'b1, 1'b0);
    checkVal("unstall.gnt", {28'd0, gnt}, 32'b0010);
    tick();
    checkVal("unstall.data", outData, 32'hBBBB0001);

    // Drain to EMPTY, then a late request from D.
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("drain");
    tick();
    checkVal("drain.valid", {31'd0, outValid}, 32'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("idle");
    tick();
    dataArr[3] = 32'hDDDD0003;
    applyStimulus(4'b1000, 1'b0, 1'b0);
    checkOutput("reqD");
    checkVal("reqD.gnt", {28'd0, gnt}, 32'b1000);
    tick();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) if (!r[i] || !req[i]) dataArr[i] = $urandom;
      applyStimulus(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
      checkOutput("rand");
      tick();
    end

    // Reset while FULL with all requesting, then first grant goes to A.
    applyStimulus(4'b1111, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b1111, 1'b1, 1'b0);
    tick();
    applyStimulus(4'b1111, 1'b0, 1'b1);
    checkVal("rstFull.gnt", {28'd0, gnt}, 32'd0);
    checkVal("rstFull.sel", {30'd0, sel}, 32'd3);
    tick();
    checkVal("rstFull.valid", {31'd0, outValid}, 32'd0);
    checkVal("rstFull.data", outData, 32'd0);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("postRst");
    checkVal("postRst.gnt", {28'd0, gnt}, 32'b0001);
    tick();

    // Counter wrap: 65535 captures, then one more.
    applyStimulus(4'b0000, 1'b1, 1'b1);
    tick();
    applyStimulus(4'b0001, 1'b1, 1'b0);
    for (int n = 0; n < 65535; n++) tick();
    checkOutput("wrapPre");
    checkVal("wrap.ffff", {16'd0, xferCount}, 32'h0000FFFF);
    tick();
    checkVal("wrap.zero", {16'd0, xferCount}, 32'd0);
    checkVal("wrap.valid", {31'd0, outValid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
